// File: rtl/lib_arb_pkg.sv
// lib_arb_pkg: shared types and helpers for the weighted round-robin arbiters.
//   arb_state_t : arbiter state (ARB = free to arbitrate, LOCKED = packet in flight)
//   onehot2idx  : binary index of a one-hot vector (bit i = requester i)
//   rotl1       : move a one-hot bit from position i to (i+1) mod n
// Helpers operate on MAX_N-wide little-endian vectors; callers size-cast to N.
package lib_arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;

  function automatic int onehot2idx(input logic [MAX_N-1:0] v, input int n);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if ((i < n) && v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Bit n-1 wraps to bit 0; bits at n and above are cleared.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    mask = (MAX_N'(1) << n) - MAX_N'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/lib_ppe_core.sv
// lib_ppe_core: combinational programmable priority encoder.
//   i_request  [N-1:0] request vector, bit i = requester i
//   i_priority [N-1:0] one-hot: position where the cyclic search starts
//   o_grant    [N-1:0] one-hot grant to the first requester at or after the
//                      priority position (wrapping N-1 -> 0), zero if none
module lib_ppe_core
  import lib_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_request,
  input  logic [N-1:0] i_priority,
  output logic [N-1:0] o_grant
);

  // The carry chain is unrolled over two passes instead of closing the loop,
  // so there is no combinational cycle. Once a grant is made the carry dies;
  // the second pass can only re-grant the same requester, so OR-ing keeps
  // the result one-hot.
  always_comb begin : ppe_chain
    logic carry;
    logic carry_in;
    int   k;
    o_grant  = '0;
    carry    = 1'b0;
    carry_in = 1'b0;
    k        = 0;
    for (int j = 0; j < 2 * N; j++) begin
      k        = j % N;
      carry_in = carry | i_priority[k];
      if (carry_in && i_request[k]) o_grant[k] = 1'b1;
      carry    = carry_in & ~i_request[k];
    end
  end

endmodule

// File: rtl/lib_wrr_lock_arbiter.sv
// lib_wrr_lock_arbiter: N-input weighted round-robin arbiter with packet lock.
//   clk, reset_n    clock; synchronous active-low reset
//   i_request       [0:N-1] request vector
//   i_tail          [0:N-1] current flit of requester i is its packet's last
//   i_weight        [0:N-1][WEIGHT_W-1:0] packets per turn (0 acts as 1)
//   i_ready         downstream accepts the granted flit this cycle
//   o_grant         [0:N-1] one-hot grant, same cycle as the request
//   o_grant_vld     |o_grant
//   o_grant_idx     binary index of the grant (0 when nothing granted)
// A requester keeps priority for up to its weight in consecutive packets;
// with LOCK=1 the grant is held from the first flit of a packet to its tail.
module lib_wrr_lock_arbiter
  import lib_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int LOCK     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [0:N-1]                     i_request,
  input  logic [0:N-1]                     i_tail,
  input  logic [0:N-1][WEIGHT_W-1:0]       i_weight,
  input  logic                             i_ready,
  output logic [0:N-1]                     o_grant,
  output logic                             o_grant_vld,
  output logic [$clog2(N)-1:0]             o_grant_idx
);

  localparam int IDX_W = $clog2(N);

  arb_state_t          r_state, w_state_nxt;
  logic [N-1:0]        r_ptr, w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;

  logic [N-1:0]        w_req, w_tail, w_ppe_gnt, w_gnt, w_owner_oh;
  logic [IDX_W-1:0]    w_g;
  logic                w_vld, w_xfer, w_tail_g, w_pkt_end;
  logic [WEIGHT_W-1:0] w_cnt_c, w_wmax;

  function automatic logic [WEIGHT_W-1:0] sat_inc(input logic [WEIGHT_W-1:0] v);
    return (&v) ? v : v + WEIGHT_W'(1);
  endfunction

  // Ports are indexed [0:N-1]; internal vectors are little-endian by index.
  always_comb begin
    w_req  = '0;
    w_tail = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i]  = i_request[i];
      w_tail[i] = i_tail[i];
    end
  end

  lib_ppe_core #(.N(N)) u_ppe (
    .i_request  (w_req),
    .i_priority (r_ptr),
    .o_grant    (w_ppe_gnt)
  );

  assign w_owner_oh = N'(1) << r_owner;

  // While locked only the owner may be granted; a dropped owner request
  // yields a bubble rather than releasing the lock.
  always_comb begin
    w_gnt = '0;
    if (!reset_n)                w_gnt = '0;
    else if (r_state == LOCKED)  w_gnt = w_req & w_owner_oh;
    else                         w_gnt = w_ppe_gnt;
  end

  assign w_vld     = |w_gnt;
  assign w_g       = IDX_W'(onehot2idx(MAX_N'(w_gnt), N));
  assign w_xfer    = w_vld & i_ready;
  assign w_tail_g  = w_tail[w_g];
  assign w_pkt_end = w_xfer & (w_tail_g | (LOCK == 0));

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) o_grant[i] = w_gnt[i];
  end
  assign o_grant_vld = w_vld;
  assign o_grant_idx = w_g;

  // Consecutive packets by the same winner extend its turn; any other winner
  // starts a fresh count.
  assign w_cnt_c = (w_g == r_last) ? sat_inc(r_cnt) : WEIGHT_W'(1);
  assign w_wmax  = (i_weight[w_g] == '0) ? WEIGHT_W'(1) : i_weight[w_g];

  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    if (w_pkt_end) begin
      w_last_nxt = w_g;
      if (w_cnt_c >= w_wmax) begin
        w_ptr_nxt = N'(rotl1(MAX_N'(w_gnt), N));
        w_cnt_nxt = '0;
      end else begin
        w_ptr_nxt = w_gnt;
        w_cnt_nxt = w_cnt_c;
      end
    end
  end

  // Next-state logic; in LOCKED any transfer necessarily belongs to the owner.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ARB: begin
        if (w_xfer && (LOCK != 0) && !w_tail_g) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_g;
        end
      end
      LOCKED: begin
        if (w_xfer && w_tail_g) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ARB;
      r_owner <= '0;
      r_ptr   <= N'(1);
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_lib_wrr_lock_arbiter.sv
// Bench for lib_wrr_lock_arbiter: one instance with LOCK=0, one with LOCK=1,
// sharing all inputs. Expected grants are queued as stimulus is applied and
// compared on the falling edge.
module tb_lib_wrr_lock_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [0:3]       req, tail;
  logic [0:3][3:0]  weight;
  logic             ready;
  logic [0:3]       g0, g1;
  logic             v0, v1;
  logic [1:0]       x0, x1;
  logic [6:0]       w0, w1;

  int checks = 0;
  int errors = 0;
  logic [6:0] q0[$];
  logic [6:0] q1[$];

  // reference model state, index 0 = LOCK=0 instance, 1 = LOCK=1 instance
  int m_ptr[2], m_cnt[2], m_last[2], m_owner[2];
  bit m_lock[2];

  always #5 clk = ~clk;

  lib_wrr_lock_arbiter #(.N(4), .WEIGHT_W(4), .LOCK(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_request(req), .i_tail(tail),
    .i_weight(weight), .i_ready(ready),
    .o_grant(g0), .o_grant_vld(v0), .o_grant_idx(x0));

  lib_wrr_lock_arbiter #(.N(4), .WEIGHT_W(4), .LOCK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_request(req), .i_tail(tail),
    .i_weight(weight), .i_ready(ready),
    .o_grant(g1), .o_grant_vld(v1), .o_grant_idx(x1));

  assign w0 = {g0, v0, x0};
  assign w1 = {g1, v1, x1};

  // {grant[0:3], vld, idx} expected for a grant to idx (-1 = no grant)
  function automatic logic [6:0] ew(input int idx);
    logic [3:0] g;
    if (idx < 0) return 7'd0;
    g = 4'b1000 >> idx;
    return {g, 1'b1, idx[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tail    = '0;
    ready   = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  function automatic int model_grant(input int d);
    int i;
    if (!reset_n) return -1;
    if (m_lock[d]) return req[m_owner[d]] ? m_owner[d] : -1;
    for (int k = 0; k < 4; k++) begin
      i = (m_ptr[d] + k) % 4;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_step(input int d);
    int g, c, wm;
    if (!reset_n) begin
      m_ptr[d] = 0; m_cnt[d] = 0; m_last[d] = 0; m_owner[d] = 0; m_lock[d] = 0;
      return;
    end
    g = model_grant(d);
    if (g < 0 || !ready) return;
    if (d == 1 && !m_lock[d] && !tail[g]) begin
      m_lock[d]  = 1;
      m_owner[d] = g;
    end else if (m_lock[d] && tail[g]) begin
      m_lock[d] = 0;
    end
    if (tail[g] || d == 0) begin
      c = (g == m_last[d]) ? ((m_cnt[d] + 1 > 15) ? 15 : m_cnt[d] + 1) : 1;
      m_last[d] = g;
      wm = (weight[g] == 0) ? 1 : int'(weight[g]);
      if (c >= wm) begin
        m_ptr[d] = (g + 1) % 4;
        m_cnt[d] = 0;
      end else begin
        m_ptr[d] = g;
        m_cnt[d] = c;
      end
    end
  endfunction

  task automatic test_reset();
    logic [6:0] e;
    reset_n = 1'b0;
    req     = 4'b1111;
    tail    = 4'b1111;
    ready   = 1'b1;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    q0.push_back(ew(-1));
    q1.push_back(ew(-1));
    @(negedge clk);
    e = q0.pop_front(); checks++;
    if (w0 !== e) begin errors++; $display("FAIL reset_outputs_lock0 got %b exp %b", w0, e); end
    e = q1.pop_front(); checks++;
    if (w1 !== e) begin errors++; $display("FAIL reset_outputs_lock1 got %b exp %b", w1, e); end
    tick();
    reset_n = 1'b1;
    q0.push_back(ew(0));
    q1.push_back(ew(0));
    @(negedge clk);
    e = q0.pop_front(); checks++;
    if (w0 !== e) begin errors++; $display("FAIL reset_ptr0_lock0 got %b exp %b", w0, e); end
    e = q1.pop_front(); checks++;
    if (w1 !== e) begin errors++; $display("FAIL reset_ptr0_lock1 got %b exp %b", w1, e); end
    tick();
  endtask

  task automatic test_rr_equal();
    logic [6:0] e;
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req    = 4'b1111;
    tail   = 4'b0000;
    ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      q0.push_back(ew(c % 4));
      @(negedge clk);
      e = q0.pop_front(); checks++;
      if (w0 !== e) begin errors++; $display("FAIL rr_equal cyc %0d got %b exp %b", c, w0, e); end
      tick();
    end
  endtask

  task automatic test_weighted(input logic [3:0] w2);
    logic [6:0] e;
    int exp_seq[9];
    exp_seq = '{0, 0, 1, 2, 3, 3, 3, 0, 0};
    do_reset();
    weight = {4'd2, 4'd1, w2, 4'd3};
    req    = 4'b1111;
    tail   = 4'b0000;
    ready  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      q0.push_back(ew(exp_seq[c]));
      @(negedge clk);
      e = q0.pop_front(); checks++;
      if (w0 !== e) begin errors++; $display("FAIL weighted w2=%0d cyc %0d got %b exp %b", w2, c, w0, e); end
      tick();
    end
  endtask

  task automatic test_lock_packet();
    logic [6:0] e;
    logic [3:0] rq[8];
    logic [3:0] tl[8];
    int ex[8];
    // cycles 0-3: 3-flit packet from req0; 4-7: req0 drops mid-packet
    rq = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b1100, 4'b0100};
    tl = '{4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    ex = '{0, 0, 0, 1, 0, -1, 0, 1};
    for (int c = 0; c < 8; c++) begin
      if (c == 0 || c == 4) do_reset();
      weight = {4'd1, 4'd1, 4'd1, 4'd1};
      req    = rq[c];
      tail   = tl[c];
      ready  = 1'b1;
      q1.push_back(ew(ex[c]));
      @(negedge clk);
      e = q1.pop_front(); checks++;
      if (w1 !== e) begin errors++; $display("FAIL lock_packet cyc %0d got %b exp %b", c, w1, e); end
      tick();
    end
  endtask

  task automatic test_ready_stall();
    logic [6:0] e;
    logic rd[5];
    int ex[5];
    rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ex = '{1, 1, 1, 1, 2};
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req    = 4'b0110;
    tail   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      ready = rd[c];
      q0.push_back(ew(ex[c]));
      q1.push_back(ew(ex[c]));
      @(negedge clk);
      e = q0.pop_front(); checks++;
      if (w0 !== e) begin errors++; $display("FAIL ready_stall_lock0 cyc %0d got %b exp %b", c, w0, e); end
      e = q1.pop_front(); checks++;
      if (w1 !== e) begin errors++; $display("FAIL ready_stall_lock1 cyc %0d got %b exp %b", c, w1, e); end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [6:0] e;
    logic [3:0] rq[5];
    logic [3:0] tl[5];
    logic rs[5];
    int ex[5];
    rq = '{4'b0010, 4'b0011, 4'b0011, 4'b1010, 4'b0010};
    tl = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
    rs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ex = '{2, 2, -1, 0, 2};
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    ready  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      reset_n = rs[c];
      req     = rq[c];
      tail    = tl[c];
      q1.push_back(ew(ex[c]));
      @(negedge clk);
      e = q1.pop_front(); checks++;
      if (w1 !== e) begin errors++; $display("FAIL reset_mid_packet cyc %0d got %b exp %b", c, w1, e); end
      tick();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] e;
    int starve[2][4];
    int worst;
    bit hold;
    int hold_idx;
    bit pend;
    logic [0:3] gd;
    logic [1:0] xd;
    logic vd;
    do_reset();
    weight = {4'd1, 4'd2, 4'd0, 4'd3};
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_cnt[d] = 0; m_last[d] = 0; m_owner[d] = 0; m_lock[d] = 0;
      for (int i = 0; i < 4; i++) starve[d][i] = 0;
    end
    hold = 0;
    hold_idx = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      req     = 4'($urandom);
      for (int i = 0; i < 4; i++) tail[i] = ($urandom_range(0, 2) == 0);
      ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0)
        for (int i = 0; i < 4; i++) weight[i] = 4'($urandom_range(0, 3));
      q0.push_back(ew(model_grant(0)));
      q1.push_back(ew(model_grant(1)));
      @(negedge clk);
      e = q0.pop_front(); checks++;
      if (w0 !== e) begin errors++; $display("FAIL random_lock0 cyc %0d got %b exp %b", cyc, w0, e); end
      e = q1.pop_front(); checks++;
      if (w1 !== e) begin errors++; $display("FAIL random_lock1 cyc %0d got %b exp %b", cyc, w1, e); end
      checks++;
      if ($countones(g0) > 1 || $countones(g1) > 1) begin
        errors++; $display("FAIL random_onehot cyc %0d got %b %b exp at most one bit", cyc, g0, g1);
      end
      if (hold && reset_n) begin
        checks++;
        if (v1 && int'(x1) != hold_idx) begin
          errors++; $display("FAIL random_owner_change cyc %0d got idx %0d exp %0d", cyc, x1, hold_idx);
        end
      end
      if (!reset_n) hold = 0;
      else if (v1 && ready) begin hold = !tail[x1]; hold_idx = int'(x1); end
      for (int d = 0; d < 2; d++) begin
        gd = (d == 0) ? g0 : g1;
        vd = (d == 0) ? v0 : v1;
        xd = (d == 0) ? x0 : x1;
        pend = vd && ready && (tail[xd] || d == 0);
        worst = 0;
        for (int i = 0; i < 4; i++) begin
          if (!reset_n || !req[i] || gd[i]) starve[d][i] = 0;
          else if (pend) starve[d][i]++;
          if (starve[d][i] > worst) worst = starve[d][i];
        end
        checks++;
        if (worst > 64) begin
          errors++; $display("FAIL random_starvation dut%0d cyc %0d got %0d packets exp <= 64", d, cyc, worst);
        end
      end
      model_step(0);
      model_step(1);
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    tail    = '0;
    ready   = 1'b0;
    weight  = '0;
    tick();
    test_reset();
    test_rr_equal();
    test_weighted(4'd1);
    test_weighted(4'd0);
    test_lock_packet();
    test_ready_stall();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
